// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and line-level constants for the UART transmitter
//
// Purpose : transmitter FSM state encoding and UART line levels.
// Contents: uart_state_e (IDLE, START, DATA, PARITY, STOP), UART_IDLE, UART_START.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam logic UART_IDLE  = 1'b1;
  localparam logic UART_START = 1'b0;

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - baud-period counter with synchronous clear and end-of-bit tick
//
// Purpose : counts 0..CLOCKS_PER_PULSE-1 and flags the last cycle of each bit period.
// Ports   : clk     - clock
//           rstn    - asynchronous active-low reset
//           clear_i - forces the count back to 0 on the next edge
//           tick_o  - high during the cycle in which the count equals CLOCKS_PER_PULSE-1
module uart_baud_tick #(
  parameter int CLOCKS_PER_PULSE = 8680
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear_i,
  output logic tick_o
);

  localparam int CW = (CLOCKS_PER_PULSE > 1) ? $clog2(CLOCKS_PER_PULSE) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CW'(CLOCKS_PER_PULSE - 1));

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/axis_uart_tx.sv
// rtl/axis_uart_tx.sv - AXI-Stream word to UART serial transmitter
//
// Purpose : accepts one W_IN-bit word and sends it as W_IN/BITS_PER_WORD UART frames,
//           lowest slice first, each frame LSB first with one start and one stop bit.
//           Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
// Ports   : clk     - clock, rising edge
//           rstn    - asynchronous active-low reset
//           s_valid - input word valid
//           s_data  - input word (W_IN bits)
//           s_ready - registered; high only while idle
//           tx      - registered UART line, idle high
//           busy    - registered; high while any frame of the held word is in flight
module axis_uart_tx
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_PULSE = 8680,
  parameter int BITS_PER_WORD    = 8,
  parameter int W_IN             = 8
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            s_valid,
  input  logic [W_IN-1:0] s_data,
  output logic            s_ready,
  output logic            tx,
  output logic            busy
);

  localparam int N  = W_IN / BITS_PER_WORD;
  localparam int FW = (N > 1) ? $clog2(N) : 1;
  localparam int BW = (BITS_PER_WORD > 1) ? $clog2(BITS_PER_WORD) : 1;

  uart_state_e     state_q, state_d;
  logic [W_IN-1:0] shift_q, shift_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [FW-1:0]   frame_q, frame_d;
  logic            tx_q, tx_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic            tick;
  logic            baud_clr;
`ifdef UART_TX_PARITY_EN
  logic            par_q, par_d;
`endif

  // Counter restarts on every state change and is parked at 0 while idle, so
  // each state starts a full bit period regardless of where the count was.
  assign baud_clr = (state_q == IDLE) || (state_d != state_q);

  uart_baud_tick #(
    .CLOCKS_PER_PULSE(CLOCKS_PER_PULSE)
  ) u_baud (
    .clk    (clk),
    .rstn   (rstn),
    .clear_i(baud_clr),
    .tick_o (tick)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    frame_d = frame_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif

    case (state_q)
      IDLE: begin
        if (s_valid && ready_q) begin
          shift_d = s_data;
          frame_d = FW'(N - 1);
          state_d = START;
        end
      end
      START: begin
`ifdef UART_TX_PARITY_EN
        par_d = 1'b0;
`endif
        if (tick) begin
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (tick) begin
`ifdef UART_TX_PARITY_EN
          par_d = par_q ^ shift_q[0];
`endif
          // Shifting on the last bit as well leaves the next slice at the LSB.
          shift_d = shift_q >> 1;
          if (bit_q == BW'(BITS_PER_WORD - 1)) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          if (frame_q != '0) begin
            frame_d = frame_q - FW'(1);
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line and handshake outputs are registered, so they are derived from the
  // next-state values and change on the same edge as the state.
  always_comb begin
    tx_d = UART_IDLE;
    case (state_d)
      START:  tx_d = UART_START;
      DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_d = par_d;
`endif
      default: tx_d = UART_IDLE;
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      frame_q <= '0;
      tx_q    <= UART_IDLE;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      frame_q <= frame_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`endif

  assign tx      = tx_q;
  assign s_ready = ready_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_axis_uart_tx.sv
// tb/tb_axis_uart_tx.sv - directed self-checking bench for axis_uart_tx (8-bit and 16-bit words)
module tb_axis_uart_tx;

  localparam int CPP = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic        clk;
  logic        rstn;
  logic        v8, v16;
  logic [7:0]  d8;
  logic [15:0] d16;
  logic        rdy8, tx8, busy8;
  logic        rdy16, tx16, busy16;
  logic        sel;
  logic        tx_m, rdy_m, busy_m;
  int          checks;
  int          failures;
  int          hs8, hs16;

  axis_uart_tx #(.CLOCKS_PER_PULSE(CPP), .BITS_PER_WORD(8), .W_IN(8)) dut8 (
    .clk(clk), .rstn(rstn), .s_valid(v8), .s_data(d8),
    .s_ready(rdy8), .tx(tx8), .busy(busy8)
  );

  axis_uart_tx #(.CLOCKS_PER_PULSE(CPP), .BITS_PER_WORD(8), .W_IN(16)) dut16 (
    .clk(clk), .rstn(rstn), .s_valid(v16), .s_data(d16),
    .s_ready(rdy16), .tx(tx16), .busy(busy16)
  );

  assign tx_m   = sel ? tx16   : tx8;
  assign rdy_m  = sel ? rdy16  : rdy8;
  assign busy_m = sel ? busy16 : busy8;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hs8  <= 0;
      hs16 <= 0;
    end else begin
      if (v8 && rdy8)   hs8  <= hs8 + 1;
      if (v16 && rdy16) hs16 <= hs16 + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Line bits in time order: start, data LSB first, optional even parity, stop.
  function automatic logic [10:0] frame_bits(input logic [7:0] b);
    logic [10:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = b;
`ifdef UART_TX_PARITY_EN
    f[9]   = ^b;
`endif
    return f;
  endfunction

  task automatic capture_frame(input string tag, input logic [7:0] b, output int busy_cnt);
    logic [10:0] obs;
    int unstable;
    obs      = '1;
    unstable = 0;
    busy_cnt = 0;
    for (int k = 0; k < FB; k++) begin
      for (int c = 0; c < CPP; c++) begin
        @(negedge clk);
        if (c == 0) obs[k] = tx_m;
        else if (tx_m !== obs[k]) unstable++;
        if (busy_m) busy_cnt++;
      end
    end
    check_eq({tag, "_bits"}, 32'(obs), 32'(frame_bits(b)));
    check_eq({tag, "_stable"}, unstable, 0);
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!rdy_m && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_ready"}, 32'(rdy_m), 1);
  endtask

  task automatic send_word(input logic s, input logic [15:0] w, input int nfr, input string tag);
    int hs0, bc, total;
    sel = s;
    wait_ready(tag);
    hs0 = s ? hs16 : hs8;
    if (s) begin v16 = 1'b1; d16 = w; end
    else   begin v8  = 1'b1; d8  = w[7:0]; end
    @(posedge clk);
    #1;
    // Drop valid and corrupt the data bus: the frame must use the captured word.
    if (s) begin v16 = 1'b0; d16 = ~w; end
    else   begin v8  = 1'b0; d8  = ~w[7:0]; end
    total = 0;
    for (int f = 0; f < nfr; f++) begin
      capture_frame($sformatf("%s_f%0d", tag, f), w[8*f +: 8], bc);
      total += bc;
    end
    check_eq({tag, "_busy_cycles"}, total, nfr * FB * CPP);
    @(negedge clk);
    check_eq({tag, "_end_ready"}, 32'(rdy_m), 1);
    check_eq({tag, "_end_tx"}, 32'(tx_m), 1);
    check_eq({tag, "_end_busy"}, 32'(busy_m), 0);
    check_eq({tag, "_accepts"}, (s ? hs16 : hs8) - hs0, 1);
  endtask

  initial begin
    int bc, hs0, extra;
    checks   = 0;
    failures = 0;
    sel  = 1'b0;
    rstn = 1'b0;
    v8   = 1'b0;
    v16  = 1'b0;
    d8   = '0;
    d16  = '0;

    repeat (3) @(negedge clk);
    check_eq("rst_tx8", 32'(tx8), 1);
    check_eq("rst_ready8", 32'(rdy8), 0);
    check_eq("rst_busy8", 32'(busy8), 0);
    check_eq("rst_tx16", 32'(tx16), 1);
    check_eq("rst_ready16", 32'(rdy16), 0);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rel_ready8", 32'(rdy8), 1);
    check_eq("rel_ready16", 32'(rdy16), 1);

    send_word(1'b0, 16'h0055, 1, "w8_55");
    send_word(1'b1, 16'hA53C, 2, "w16_a53c");
    send_word(1'b0, 16'h00C6, 1, "w8_c6");

    // s_valid held across two words: one idle cycle between frames.
    sel = 1'b0;
    wait_ready("b2b");
    hs0 = hs8;
    v8  = 1'b1;
    d8  = 8'h01;
    @(posedge clk);
    #1;
    d8 = 8'h02;
    capture_frame("b2b_f0", 8'h01, bc);
    @(negedge clk);
    check_eq("b2b_gap_tx", 32'(tx8), 1);
    check_eq("b2b_gap_ready", 32'(rdy8), 1);
    check_eq("b2b_gap_busy", 32'(busy8), 0);
    @(posedge clk);
    #1;
    v8 = 1'b0;
    capture_frame("b2b_f1", 8'h02, bc);
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (tx8 !== 1'b1 || busy8 !== 1'b0) extra++;
    end
    check_eq("b2b_quiet", extra, 0);
    check_eq("b2b_accepts", hs8 - hs0, 2);

    // Reset pulse at cycle 17 of a 0xFF frame.
    wait_ready("rst_mid");
    v8 = 1'b1;
    d8 = 8'hFF;
    @(posedge clk);
    #1;
    v8 = 1'b0;
    repeat (17) @(negedge clk);
    check_eq("rst_mid_busy_before", 32'(busy8), 1);
    #1;
    rstn = 1'b0;
    #1;
    check_eq("rst_mid_tx", 32'(tx8), 1);
    check_eq("rst_mid_busy", 32'(busy8), 0);
    check_eq("rst_mid_ready", 32'(rdy8), 0);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_mid_rel_ready", 32'(rdy8), 1);
    check_eq("rst_mid_rel_tx", 32'(tx8), 1);
    send_word(1'b0, 16'h0000, 1, "post_rst_00");

    // Parity frames (even parity when enabled: 0x07 -> 1, 0x03 -> 0).
    send_word(1'b0, 16'h0007, 1, "par_07");
    send_word(1'b0, 16'h0003, 1, "par_03");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
